// File: rtl/fishingrod_dec_control.sv
// Decryption-direction sequencer for the parallel Fishingrod core.
// Rolls the key schedule forward to the last round key, then walks rounds back down to 0.
module fishingrod_dec_control #(
    parameter int LAST_ROUND = 18,
    parameter int RW         = 5
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          keyfwd,
    output logic          round0,
    output logic [RW-1:0] round,
    output logic [3:0]    sels,
    output logic [3:0]    selk,
    output logic          ready
);

    typedef enum logic [1:0] {
        IDLE,
        KEYFWD,
        DEC,
        DONE
    } state_t;

    localparam logic [RW-1:0] LAST = RW'(LAST_ROUND);

    state_t     state;
    logic [2:0] cnt;
    logic [7:0] enc_sel;

    // Encryption-direction select table, {sels,selk} per sub-cycle.
    function automatic logic [7:0] enc_table(input logic [2:0] c);
        logic [7:0] e;
        case (c)
            3'd0:    e = 8'b0111_0000;
            3'd1:    e = 8'b1011_0000;
            3'd2:    e = 8'b1001_0010;
            3'd3:    e = 8'b0000_0101;
            3'd4:    e = 8'b0111_1001;
            3'd5:    e = 8'b0011_1000;
            3'd6:    e = 8'b0001_1000;
            default: e = 8'b0000_1100;
        endcase
        return e;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
            round <= '0;
        end else if (start) begin
            state <= KEYFWD;
            cnt   <= 3'd0;
            round <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt   <= 3'd0;
                    round <= '0;
                end
                KEYFWD: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        if (round == LAST) begin
                            state <= DEC;
                        end else begin
                            round <= round + RW'(1);
                        end
                    end
                end
                DEC: begin
                    cnt <= cnt + 3'd1;
                    // Round 0 finishes without decrementing, so the index never underflows.
                    if (cnt == 3'd7) begin
                        if (round == '0) begin
                            state <= DONE;
                        end else begin
                            round <= round - RW'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= 3'd0;
                    round <= '0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 3'd0;
                    round <= '0;
                end
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        busy    = 1'b0;
        keyfwd  = 1'b0;
        ready   = 1'b0;
        sels    = 4'b0000;
        selk    = 4'b0000;
        enc_sel = 8'd0;
        case (state)
            KEYFWD: begin
                busy    = 1'b1;
                keyfwd  = 1'b1;
                enc_sel = enc_table(cnt);
                selk    = enc_sel[3:0];
            end
            DEC: begin
                busy          = 1'b1;
                // Decryption replays the encryption sub-cycles in reverse order.
                enc_sel       = enc_table(3'd7 - cnt);
                {sels, selk}  = enc_sel;
            end
            DONE: begin
                ready = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
        round0 = busy & (round == '0);
    end

endmodule

// File: tb/tb_fishingrod_dec_control.sv
// Directed self-checking bench for fishingrod_dec_control.
// Each test compares {busy,keyfwd,round0,ready,round,sels,selk} against a small timing model.
module tb_fishingrod_dec_control;

    localparam int LAST_ROUND = 18;
    localparam int RW         = 5;
    localparam int PHASE      = 8 * (LAST_ROUND + 1);   // 152
    localparam int READY_K    = 2 * PHASE;              // 304 edges after the start edge

    logic          ck;
    logic          rst;
    logic          start;
    logic          busy;
    logic          keyfwd;
    logic          round0;
    logic [RW-1:0] round;
    logic [3:0]    sels;
    logic [3:0]    selk;
    logic          ready;

    int checks;
    int errors;

    logic [16:0] obs;
    assign obs = {busy, keyfwd, round0, ready, round, sels, selk};

    // Encryption table {sels,selk} written out by hand.
    logic [7:0] e_tab [8];
    initial begin
        e_tab[0] = 8'b0111_0000;
        e_tab[1] = 8'b1011_0000;
        e_tab[2] = 8'b1001_0010;
        e_tab[3] = 8'b0000_0101;
        e_tab[4] = 8'b0111_1001;
        e_tab[5] = 8'b0011_1000;
        e_tab[6] = 8'b0001_1000;
        e_tab[7] = 8'b0000_1100;
    end

    fishingrod_dec_control #(
        .LAST_ROUND(LAST_ROUND),
        .RW        (RW)
    ) dut (
        .ck    (ck),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .keyfwd(keyfwd),
        .round0(round0),
        .round (round),
        .sels  (sels),
        .selk  (selk),
        .ready (ready)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Expected output vector k edges after the edge that sampled start.
    function automatic logic [16:0] exp_vec(input int k);
        logic [7:0] e;
        int r;
        int c;
        int j;
        if (k < PHASE) begin
            r = k / 8;
            c = k % 8;
            e = e_tab[c];
            return {1'b1, 1'b1, (r == 0), 1'b0, 5'(r), 4'b0000, e[3:0]};
        end else if (k < READY_K) begin
            j = k - PHASE;
            r = LAST_ROUND - j / 8;
            c = j % 8;
            e = e_tab[7 - c];
            return {1'b1, 1'b0, (r == 0), 1'b0, 5'(r), e};
        end else if (k == READY_K) begin
            return {4'b0001, 13'd0};
        end
        return 17'd0;
    endfunction

    task automatic step();
        @(posedge ck);
        @(negedge ck);
    endtask

    // Drive start for one edge; returns at the negedge after that edge (k = 0).
    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        step();
        checks++;
        if (obs !== 17'd0) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", obs, 17'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (obs !== 17'd0) begin
                errors++;
                $display("FAIL idle cycle %0d: got %h want %h", i, obs, 17'd0);
            end
        end
    endtask

    task automatic test_full_run();
        pulse_start();
        for (int k = 0; k <= READY_K + 3; k++) begin
            checks++;
            if (obs !== exp_vec(k)) begin
                errors++;
                $display("FAIL full_run k=%0d: got %h want %h", k, obs, exp_vec(k));
            end
            if (k == PHASE) begin
                checks++;
                if ({sels, selk} !== 8'b0000_1100) begin
                    errors++;
                    $display("FAIL dec_cnt0_selects: got %b want 00001100", {sels, selk});
                end
            end
            if (k == PHASE + 7) begin
                checks++;
                if ({sels, selk} !== 8'b0111_0000) begin
                    errors++;
                    $display("FAIL dec_cnt7_selects: got %b want 01110000", {sels, selk});
                end
            end
            step();
        end
    endtask

    task automatic test_restart();
        pulse_start();
        // DEC round 10 is reached 64 cycles into the decrypt phase.
        for (int k = 0; k < PHASE + 64; k++) step();
        checks++;
        if (round !== 5'd10 || keyfwd !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_pre: got round=%0d keyfwd=%b busy=%b want 10 0 1", round, keyfwd, busy);
        end
        pulse_start();
        for (int k = 0; k <= READY_K + 2; k++) begin
            checks++;
            if (obs !== exp_vec(k)) begin
                errors++;
                $display("FAIL restart k=%0d: got %h want %h", k, obs, exp_vec(k));
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        pulse_start();
        for (int k = 0; k < 40; k++) step();
        checks++;
        if (round !== 5'd5 || keyfwd !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: got round=%0d keyfwd=%b want 5 1", round, keyfwd);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 17'd0) begin
            errors++;
            $display("FAIL async_reset_immediate: got %h want %h", obs, 17'd0);
        end
        rst = 1'b0;
        @(negedge ck);
        for (int i = 0; i < 30; i++) begin
            checks++;
            if (obs !== 17'd0) begin
                errors++;
                $display("FAIL async_after cycle %0d: got %h want %h", i, obs, 17'd0);
            end
            step();
        end
        pulse_start();
        for (int k = 0; k <= READY_K + 1; k++) begin
            checks++;
            if (obs !== exp_vec(k)) begin
                errors++;
                $display("FAIL async_rerun k=%0d: got %h want %h", k, obs, exp_vec(k));
            end
            step();
        end
    endtask

    task automatic test_start_on_done();
        pulse_start();
        for (int k = 0; k < READY_K; k++) step();
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL done_ready: got %b want 1", ready);
        end
        pulse_start();
        for (int k = 0; k < 24; k++) begin
            checks++;
            if (obs !== exp_vec(k)) begin
                errors++;
                $display("FAIL start_on_done k=%0d: got %h want %h", k, obs, exp_vec(k));
            end
            step();
        end
    endtask

    task automatic test_hold_start();
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if (obs !== exp_vec(0)) begin
                errors++;
                $display("FAIL hold_start cycle %0d: got %h want %h", i, obs, exp_vec(0));
            end
        end
        start = 1'b0;
        // The last held edge counts as k = 0; continue the model from k = 1.
        for (int k = 1; k <= READY_K + 2; k++) begin
            step();
            checks++;
            if (obs !== exp_vec(k)) begin
                errors++;
                $display("FAIL hold_release k=%0d: got %h want %h", k, obs, exp_vec(k));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        @(negedge ck);
        test_reset();
        test_full_run();
        test_restart();
        test_async_reset();
        test_start_on_done();
        test_hold_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
